cdc_level_sync: RTL and testbench



---
 rtl/cdc_level_sync.sv | 77 +++++++
 tb/tb_cdc_level_sync.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_level_sync.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cdc_level_sync
//
// Multi-flop level synchronizer. It brings a slow, level-type control signal
// from the clk1 domain into the clk2 domain. The clk1-side source register sits
// upstream, so `in` is treated as fully asynchronous to clk2, which is this
// block's only clock. The block also derives single-cycle rise/fall pulses from
// the synchronized level for downstream clk2 logic.
//
// Parameters
//   SYNC_STAGES : synchronizer depth in flops, legal range 2..4.
//   RESET_VAL   : value held by every synchronizer stage, and so on out,
//                 while rst is asserted.
//
// Ports
//   clk2 : in  - sole clock; all state changes on its rising edge.
//   rst  : in  - asynchronous active-high reset.
//   in   : in  - level from the clk1 domain, asynchronous to clk2.
//   out  : out - synchronized copy of in, driven directly by the last stage flop.
//   rise : out - one-clk2-cycle pulse when out goes 0->1.
//   fall : out - one-clk2-cycle pulse when out goes 1->0.
// -----------------------------------------------------------------------------
module cdc_level_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk2,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    // Reject unsupported depths at elaboration. One flop gives no real
    // metastability protection, and more than four only adds latency.
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
        $error("cdc_level_sync: SYNC_STAGES must be in 2..4");
    end

    // Synchronizer chain. Bit 0 is the flop that captures the asynchronous input
    // and may go metastable. ASYNC_REG keeps the chain packed together so each
    // stage has the most settling time. No logic is placed between stages.
    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Previous value of out, used for edge detection.
    logic out_prev_q;
    logic out_prev_d;

    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], in};
        out_prev_d = sync_q[SYNC_STAGES-1];
    end

    // Reset loads RESET_VAL into both the chain and the history flop. out and
    // out_prev_q then agree, so neither entering nor leaving reset can raise an
    // edge pulse. A level already in flight is discarded.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            sync_q     <= {SYNC_STAGES{RESET_VAL}};
            out_prev_q <= RESET_VAL;
        end else begin
            sync_q     <= sync_d;
            out_prev_q <= out_prev_d;
        end
    end

    assign out = sync_q[SYNC_STAGES-1];

    // Both operands come straight from flops in the same clock domain, so each
    // pulse is exactly one clk2 cycle wide and does not depend on `in`.
    assign rise = sync_q[SYNC_STAGES-1] & ~out_prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & out_prev_q;

endmodule

// File: tb/tb_cdc_level_sync.sv
`timescale 1ns/1ps
module tb_cdc_level_sync;

    logic clk1 = 1'b0;
    logic clk2 = 1'b0;
    logic rst  = 1'b0;
    logic din  = 1'b0;
    logic dout;
    logic rise;
    logic fall;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_rise = 0;
    int n_fall = 0;

    cdc_level_sync #(
        .SYNC_STAGES(2),
        .RESET_VAL  (1'b0)
    ) dut (
        .clk2(clk2),
        .rst (rst),
        .in  (din),
        .out (dout),
        .rise(rise),
        .fall(fall)
    );

    // clk2: 14 ns period, posedges at 7, 21, 35, ...
    initial forever #7 clk2 = ~clk2;

    // clk1: 10 ns period; negedges fall on odd ns, never on a clk2 negedge.
    initial begin
        #2;
        forever begin
            clk1 = 1'b1;
            #5 clk1 = 1'b0;
            #5;
        end
    end

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk2) begin
        if (rise === 1'b1) n_rise++;
        if (fall === 1'b1) n_fall++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reset held 0..12 ns with in=0; then release and raise in at 13 ns.
    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b1;
        din = 1'b0;
        #5;
        got = {dout, rise, fall};
        n_cmp++;
        if (got !== 3'b000) begin
            n_err++;
            $display("FAIL reset_t5: {out,rise,fall}=%b expected 000", got);
        end
        #5;  // t=10, after the clk2 edge at 7
        got = {dout, rise, fall};
        n_cmp++;
        if (got !== 3'b000) begin
            n_err++;
            $display("FAIL reset_t10: {out,rise,fall}=%b expected 000", got);
        end
        #2 rst = 1'b0;  // t=12
        #1 din = 1'b1;  // t=13
    endtask

    // in rose at 13: sampled at 21, out=1 at 35, rise high 35..49.
    task automatic test_rise();
        logic [2:0] got;
        logic [2:0] exp_tab [4];
        exp_tab[0] = 3'b000;  // t=14
        exp_tab[1] = 3'b000;  // t=28
        exp_tab[2] = 3'b110;  // t=42
        exp_tab[3] = 3'b100;  // t=56
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== exp_tab[i]) begin
                n_err++;
                $display("FAIL rise_%0d @%0t: {out,rise,fall}=%b expected %b", i, $time, got, exp_tab[i]);
            end
        end
    endtask

    // in has been 1 for more than 3 cycles; drop it at the t=56 negedge.
    // First sampling posedge is 63, and out falls at 77.
    task automatic test_fall();
        logic [2:0] got;
        logic [2:0] exp_tab [3];
        exp_tab[0] = 3'b100;  // t=70
        exp_tab[1] = 3'b001;  // t=84
        exp_tab[2] = 3'b000;  // t=98
        din = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== exp_tab[i]) begin
                n_err++;
                $display("FAIL fall_%0d @%0t: {out,rise,fall}=%b expected %b", i, $time, got, exp_tab[i]);
            end
        end
    endtask

    // Eight alternating levels, each set one clk1 negedge then one clk2 negedge
    // after the previous one, and held for three clk2 negedges.
    task automatic test_alternate();
        logic       lvl;
        logic       prev;
        logic [2:0] got;
        logic [2:0] exp;
        int         r0;
        int         f0;
        prev = 1'b0;
        @(negedge clk1);
        #1;
        r0 = n_rise;
        f0 = n_fall;
        for (int k = 0; k < 8; k++) begin
            lvl = ((k % 2) == 0);
            @(negedge clk1);
            @(negedge clk2);
            din = lvl;
            @(negedge clk2);
            got = {dout, rise, fall};
            exp = {prev, 2'b00};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alt_%0d_hold @%0t: {out,rise,fall}=%b expected %b", k, $time, got, exp);
            end
            @(negedge clk2);
            got = {dout, rise, fall};
            exp = {lvl, lvl, ~lvl};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alt_%0d_edge @%0t: {out,rise,fall}=%b expected %b", k, $time, got, exp);
            end
            @(negedge clk2);
            got = {dout, rise, fall};
            exp = {lvl, 2'b00};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alt_%0d_settle @%0t: {out,rise,fall}=%b expected %b", k, $time, got, exp);
            end
            prev = lvl;
        end
        #1;
        n_cmp++;
        if ((n_rise - r0) !== 4) begin
            n_err++;
            $display("FAIL alt_rise_count: got %0d expected 4", n_rise - r0);
        end
        n_cmp++;
        if ((n_fall - f0) !== 4) begin
            n_err++;
            $display("FAIL alt_fall_count: got %0d expected 4", n_fall - f0);
        end
    endtask

    // Raise out to 1, put a 0 into the first stage, then assert rst
    // asynchronously between clk2 edges.
    task automatic test_reset_mid();
        logic [2:0] got;
        int         r0;
        int         f0;
        @(negedge clk2);
        din = 1'b1;
        repeat (3) @(negedge clk2);
        din = 1'b0;
        @(negedge clk2);  // 0 is in stage 0, out is still 1
        got = {dout, rise, fall};
        n_cmp++;
        if (got !== 3'b100) begin
            n_err++;
            $display("FAIL rstmid_pre: {out,rise,fall}=%b expected 100", got);
        end
        r0 = n_rise;
        f0 = n_fall;
        #2 rst = 1'b1;
        #1;  // 4 ns before the next clk2 posedge
        got = {dout, rise, fall};
        n_cmp++;
        if (got !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_async: {out,rise,fall}=%b expected 000", got);
        end
        din = 1'b1;  // in and clk2 must both be ignored while rst is held
        for (int i = 0; i < 2; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== 3'b000) begin
                n_err++;
                $display("FAIL rstmid_held_%0d: {out,rise,fall}=%b expected 000", i, got);
            end
        end
        din = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== 3'b000) begin
                n_err++;
                $display("FAIL rstmid_release_%0d: {out,rise,fall}=%b expected 000", i, got);
            end
        end
        #1;
        n_cmp++;
        if ((n_fall - f0) !== 0) begin
            n_err++;
            $display("FAIL rstmid_fall_count: got %0d expected 0", n_fall - f0);
        end
        n_cmp++;
        if ((n_rise - r0) !== 0) begin
            n_err++;
            $display("FAIL rstmid_rise_count: got %0d expected 0", n_rise - r0);
        end
    endtask

    // A 5 ns pulse that lies entirely between clk2 edges is never sampled.
    // A 5 ns pulse that straddles one posedge must come out as a clean,
    // one-cycle copy two edges later.
    task automatic test_glitch();
        logic [2:0] got;
        logic [2:0] exp_tab [4];
        @(negedge clk2);
        #1 din = 1'b1;
        #5 din = 1'b0;  // ends 1 ns before the posedge
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== 3'b000) begin
                n_err++;
                $display("FAIL glitch_between_%0d: {out,rise,fall}=%b expected 000", i, got);
            end
        end
        exp_tab[0] = 3'b000;
        exp_tab[1] = 3'b110;
        exp_tab[2] = 3'b001;
        exp_tab[3] = 3'b000;
        #5 din = 1'b1;  // 2 ns before the posedge
        #5 din = 1'b0;  // 3 ns after it
        for (int i = 0; i < 4; i++) begin
            @(negedge clk2);
            got = {dout, rise, fall};
            n_cmp++;
            if (got !== exp_tab[i]) begin
                n_err++;
                $display("FAIL glitch_span_%0d @%0t: {out,rise,fall}=%b expected %b", i, $time, got, exp_tab[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_alternate();
        test_reset_mid();
        test_glitch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
